fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, the PC value loaded on reset.
REQ-002 SHALL have parameter BUBBLE_INSTR, default 16'h0000, the instruction word driven into IF/ID on a bubble.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port stall, input, 1, hazard hold request from the decode stage.
REQ-006 SHALL have port redirect, input, 1, taken-branch (B or BR) indication from the branch-resolution logic.
REQ-007 SHALL have port redirect_pc, input, 16, the branch target PC, valid when redirect=1.
REQ-008 SHALL have port hlt_retire, input, 1, pulse from writeback when an HLT retires.
REQ-009 SHALL have port imem_addr, output, 16, the current PC, driven combinationally to instruction memory.
REQ-010 SHALL have port imem_data, input, 16, the instruction word read at imem_addr in the same cycle.
REQ-011 SHALL have port if_id_instr, output, 16, the registered instruction.
REQ-012 SHALL have port if_id_pc2, output, 16, the registered PC+2 of that instruction.
REQ-013 SHALL have port if_id_valid, output, 1, 1 = real instruction, 0 = bubble.
REQ-014 SHALL have port halted, output, 1, 1 once the processor has fully halted.

Function
REQ-015 SHALL hold a state machine with states RUN, HALT_PEND and HALTED.
REQ-016 SHALL resolve each cycle with priority rst > redirect > stall > normal fetch.
REQ-017 On redirect in RUN or HALT_PEND: PC <= redirect_pc; IF/ID <= bubble (BUBBLE_INSTR, pc2=0, valid=0); state <= RUN; stall is ignored that cycle.
REQ-018 On stall without redirect: PC, IF/ID and state all hold their values.
REQ-019 On normal fetch in RUN: if_id_instr <= imem_data, if_id_pc2 <= PC+2, if_id_valid <= 1.
REQ-020 In RUN, when imem_data[15:12] != 4'hF, PC SHALL advance: PC <= PC+2.
REQ-021 In RUN, when imem_data[15:12] == 4'hF (HLT), PC SHALL hold at the HLT address and state <= HALT_PEND.
REQ-022 In HALT_PEND without redirect: PC holds and IF/ID loads a bubble every non-stalled cycle.
REQ-023 In HALT_PEND, hlt_retire SHALL move the state to HALTED.
REQ-024 If redirect and hlt_retire coincide in HALT_PEND, redirect wins: state <= RUN.
REQ-025 HALTED SHALL be sticky until rst; redirect, stall and hlt_retire are ignored; PC holds; IF/ID holds bubble.
REQ-026 halted SHALL equal 1 exactly when state==HALTED, registered with no combinational path from any input.
REQ-027 PC+2 SHALL be computed modulo 2^16 (16'hFFFE+2 = 16'h0000) with no error flag.
REQ-028 redirect_pc SHALL be loaded unmodified; bit 0 is not forced.
REQ-029 imem_addr SHALL equal the PC register at all times.

Reset
REQ-030 Asserting rst SHALL immediately set PC=RESET_PC, if_id_instr=BUBBLE_INSTR, if_id_pc2=0, if_id_valid=0, halted=0 and state=RUN, including mid-halt and mid-stall.
REQ-031 On the first rising edge after rst deasserts, the fetch SHALL be taken from RESET_PC.

Structure
REQ-032 The shared CPU package SHALL hold the opcode constant OP_HLT=4'hF, the state encoding (RUN=2'b00, HALT_PEND=2'b01, HALTED=2'b10), RESET_PC and BUBBLE_INSTR.
REQ-033 The IF/ID pipeline register (instr, pc2, valid, with hold and flush controls) SHALL be a sub-module named if_id_reg; PC, next-PC mux and FSM stay in fetch_unit.

Verification
REQ-034 Reset then 3 non-stalled cycles with imem returning 16'h1234 -> imem_addr 0000, 0002, 0004, 0006; if_id_pc2 0002, 0004, 0006; valid=1.
REQ-035 PC=0x0010, redirect=1 with redirect_pc=0x0040 and stall=1 simultaneously -> next PC=0x0040, if_id_valid=0, if_id_instr=0x0000.
REQ-036 PC=0x0008, stall=1 for 2 cycles -> PC and IF/ID unchanged for both cycles; the following cycle resumes at 0x0008.
REQ-037 imem returns 0xF000 at PC 0x000A -> IF/ID holds 0xF000 with pc2=0x000C; PC stays 0x000A; bubbles follow; hlt_retire pulse -> halted=1 next cycle; later redirect is ignored.
REQ-038 HLT fetched at 0x000A, then redirect to 0x0020 before hlt_retire -> state RUN; PC=0x0020; halted stays 0.
REQ-039 PC=0xFFFE with a non-HLT word -> next PC=0x0000 and if_id_pc2=0x0000; a mid-cycle rst during HALT_PEND returns PC to 0x0000 asynchronously.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared CPU package: opcode, fetch FSM encoding,
// reset PC and bubble word, IF/ID bundle type.
package fetch_unit_pkg;

  localparam logic [3:0]  OP_HLT       = 4'hF;
  localparam logic [15:0] RESET_PC     = 16'h0000;
  localparam logic [15:0] BUBBLE_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    HALT_PEND = 2'b01,
    HALTED    = 2'b10
  } fetch_state_e;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc2;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold and flush.
// Flush beats hold; reset loads the bubble.
module if_id_reg #(
  parameter logic [15:0] BUBBLE_INSTR = fetch_unit_pkg::BUBBLE_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        flush,
  input  logic [15:0] instr_in,
  input  logic [15:0] pc2_in,
  input  logic        valid_in,
  output logic [15:0] instr,
  output logic [15:0] pc2,
  output logic        valid
);
  import fetch_unit_pkg::*;

  localparam if_id_t BUBBLE = '{
    instr: BUBBLE_INSTR,
    pc2:   16'h0000,
    valid: 1'b0
  };

  if_id_t r_q, r_d;

  always_comb begin
    r_d = r_q;
    if (flush) begin
      r_d = BUBBLE;
    end else if (!hold) begin
      r_d.instr = instr_in;
      r_d.pc2   = pc2_in;
      r_d.valid = valid_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= BUBBLE;
    else     r_q <= r_d;
  end

  assign instr = r_q.instr;
  assign pc2   = r_q.pc2;
  assign valid = r_q.valid;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, next-PC mux and
// halt FSM driving the IF/ID register.
module fetch_unit #(
  parameter logic [15:0] RESET_PC     = fetch_unit_pkg::RESET_PC,
  parameter logic [15:0] BUBBLE_INSTR = fetch_unit_pkg::BUBBLE_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        hlt_retire,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc2,
  output logic        if_id_valid,
  output logic        halted
);
  import fetch_unit_pkg::*;

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d, pc_plus2;
  logic         hold, flush, is_hlt;

  assign pc_plus2 = pc_q + 16'd2;
  assign is_hlt   = (imem_data[15:12] == OP_HLT);

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    hold    = 1'b1;
    flush   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (redirect) begin
          pc_d  = redirect_pc;
          flush = 1'b1;
        end else if (!stall) begin
          hold = 1'b0;
          if (is_hlt) state_d = HALT_PEND;
          else        pc_d    = pc_plus2;
        end
      end
      HALT_PEND: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          flush   = 1'b1;
          state_d = RUN;
        end else if (!stall) begin
          flush = 1'b1;
          if (hlt_retire) state_d = HALTED;
        end
      end
      HALTED: flush = 1'b1;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  if_id_reg #(
    .BUBBLE_INSTR(BUBBLE_INSTR)
  ) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .hold     (hold),
    .flush    (flush),
    .instr_in (imem_data),
    .pc2_in   (pc_plus2),
    .valid_in (1'b1),
    .instr    (if_id_instr),
    .pc2      (if_id_pc2),
    .valid    (if_id_valid)
  );

  assign imem_addr = pc_q;
  assign halted    = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed literal checks plus
// randomized run against a behavioural model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect, hlt_retire;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr, imem_data;
  logic [15:0] if_id_instr, if_id_pc2;
  logic        if_id_valid, halted;

  logic [15:0] mem [0:65535];

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  // model state: mode 0 running, 1 waiting for retire, 2 stopped
  logic [15:0] m_pc, m_instr, m_pc2;
  logic        m_valid;
  int          m_mode;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .hlt_retire  (hlt_retire),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .if_id_instr (if_id_instr),
    .if_id_pc2   (if_id_pc2),
    .if_id_valid (if_id_valid),
    .halted      (halted)
  );

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 16'h0000; m_instr = 16'h0000; m_pc2 = 16'h0000;
      m_valid = 1'b0; m_mode = 0;
    end else if (m_mode != 2) begin
      if (redirect) begin
        m_pc = redirect_pc; m_instr = 16'h0000; m_pc2 = 16'h0000;
        m_valid = 1'b0; m_mode = 0;
      end else if (!stall) begin
        if (m_mode == 0) begin
          m_instr = mem[m_pc];
          m_pc2   = m_pc + 16'd2;
          m_valid = 1'b1;
          if (m_instr[15:12] == 4'hF) m_mode = 1;
          else m_pc = m_pc + 16'd2;
        end else begin
          m_instr = 16'h0000; m_pc2 = 16'h0000; m_valid = 1'b0;
          if (hlt_retire) m_mode = 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on && !rst) begin
      chk("model_addr",   imem_addr,   m_pc);
      chk("model_instr",  if_id_instr, m_instr);
      chk("model_pc2",    if_id_pc2,   m_pc2);
      chk("model_valid",  {15'd0, if_id_valid}, {15'd0, m_valid});
      chk("model_halted", {15'd0, halted}, {15'd0, (m_mode == 2)});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [15:0] a);
    redirect = 1'b1; redirect_pc = a;
    step();
    redirect = 1'b0;
  endtask

  initial begin
    logic [15:0] w;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0;
    hlt_retire = 1'b0; redirect_pc = 16'h0000;
    for (int i = 0; i < 65536; i++) begin
      w = 16'($urandom);
      if (w[15:12] == 4'hF) w[15:12] = 4'h1;
      mem[i] = w;
    end
    mem[0] = 16'h1234; mem[2] = 16'h1234; mem[4] = 16'h1234;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr",   imem_addr, 16'h0000);
    chk("rst_instr",  if_id_instr, 16'h0000);
    chk("rst_pc2",    if_id_pc2, 16'h0000);
    chk("rst_valid",  {15'd0, if_id_valid}, 16'h0000);
    chk("rst_halted", {15'd0, halted}, 16'h0000);
    rst = 1'b0;
    chk_on = 1'b1;

    // sequential fetch
    chk("seq_addr0", imem_addr, 16'h0000);
    step();
    chk("seq_addr1", imem_addr, 16'h0002);
    chk("seq_pc2_1", if_id_pc2, 16'h0002);
    chk("seq_instr", if_id_instr, 16'h1234);
    chk("seq_valid", {15'd0, if_id_valid}, 16'h0001);
    step();
    chk("seq_addr2", imem_addr, 16'h0004);
    chk("seq_pc2_2", if_id_pc2, 16'h0004);
    step();
    chk("seq_addr3", imem_addr, 16'h0006);
    chk("seq_pc2_3", if_id_pc2, 16'h0006);

    // redirect beats stall
    redir(16'h0010);
    chk("redir_addr", imem_addr, 16'h0010);
    stall = 1'b1;
    redir(16'h0040);
    stall = 1'b0;
    chk("rs_addr",  imem_addr, 16'h0040);
    chk("rs_valid", {15'd0, if_id_valid}, 16'h0000);
    chk("rs_instr", if_id_instr, 16'h0000);

    // odd target is loaded unmodified
    redir(16'h0101);
    chk("odd_addr", imem_addr, 16'h0101);

    // two-cycle stall at 0x0008
    mem[6] = 16'h1111; mem[8] = 16'h2222;
    redir(16'h0006);
    step();
    chk("st_pre_addr", imem_addr, 16'h0008);
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("st_addr",  imem_addr, 16'h0008);
      chk("st_instr", if_id_instr, 16'h1111);
      chk("st_pc2",   if_id_pc2, 16'h0008);
    end
    stall = 1'b0;
    step();
    chk("st_res_instr", if_id_instr, 16'h2222);
    chk("st_res_pc2",   if_id_pc2, 16'h000A);
    chk("st_res_addr",  imem_addr, 16'h000A);

    // HLT at 0x000A then retire
    mem[16'h000A] = 16'hF000;
    step();
    chk("hlt_instr", if_id_instr, 16'hF000);
    chk("hlt_pc2",   if_id_pc2, 16'h000C);
    chk("hlt_addr",  imem_addr, 16'h000A);
    step();
    chk("hp_valid", {15'd0, if_id_valid}, 16'h0000);
    chk("hp_addr",  imem_addr, 16'h000A);
    chk("hp_halt",  {15'd0, halted}, 16'h0000);
    hlt_retire = 1'b1;
    step();
    hlt_retire = 1'b0;
    chk("hd_halt", {15'd0, halted}, 16'h0001);
    redir(16'h0100);
    chk("hd_redir_addr", imem_addr, 16'h000A);
    chk("hd_redir_halt", {15'd0, halted}, 16'h0001);

    // redirect cancels a pending halt
    rst = 1'b1; step(); rst = 1'b0;
    redir(16'h000A);
    step();
    step();
    redirect = 1'b1; redirect_pc = 16'h0020; hlt_retire = 1'b1;
    step();
    redirect = 1'b0; hlt_retire = 1'b0;
    chk("cx_addr", imem_addr, 16'h0020);
    chk("cx_halt", {15'd0, halted}, 16'h0000);
    mem[16'h0020] = 16'h1234;
    step();
    chk("cx_run_addr",  imem_addr, 16'h0022);
    chk("cx_run_valid", {15'd0, if_id_valid}, 16'h0001);

    // PC wrap, then async reset during a pending halt
    mem[16'hFFFE] = 16'h3000;
    redir(16'hFFFE);
    step();
    chk("wrap_addr",  imem_addr, 16'h0000);
    chk("wrap_pc2",   if_id_pc2, 16'h0000);
    chk("wrap_instr", if_id_instr, 16'h3000);
    redir(16'h000A);
    step();
    #2 rst = 1'b1;
    #1;
    chk("ar_addr",  imem_addr, 16'h0000);
    chk("ar_valid", {15'd0, if_id_valid}, 16'h0000);
    chk("ar_instr", if_id_instr, 16'h0000);
    step();
    rst = 1'b0;
    step();
    chk("ar_first_pc2",  if_id_pc2, 16'h0002);
    chk("ar_first_addr", imem_addr, 16'h0002);

    // randomized run
    for (int i = 0; i < 65536; i += 2) begin
      w = 16'($urandom);
      if ($urandom_range(7) == 0) w[15:12] = 4'hF;
      else if (w[15:12] == 4'hF) w[15:12] = 4'h2;
      mem[i] = w;
      mem[i+1] = 16'($urandom);
    end
    for (int c = 0; c < 4000; c++) begin
      stall       = ($urandom_range(3) == 0);
      redirect    = ($urandom_range(9) == 0);
      redirect_pc = 16'($urandom);
      hlt_retire  = ($urandom_range(5) == 0);
      if ($urandom_range(99) == 0) begin
        rst = 1'b1; step(); rst = 1'b0;
      end else begin
        step();
      end
    end
    stall = 1'b0; redirect = 1'b0; hlt_retire = 1'b0;
    step();
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
